ctrl_fsm: RTL and testbench

CTRL_FSM -- requirements
Module: ctrl_fsm

---
 rtl/ctrl_fsm.sv | 166 ++++++++++++++++
 tb/tb_ctrl_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle processor control unit.
// Sequences fetch / decode / memory / execute / branch / jump phases,
// latches the opcode at decode, counts retired instructions and flags
// illegal opcodes with a sticky bit that only reset clears.
module ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic [8:0] ictr,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  logic       op_legal;
  logic       retire;

  // Opcode legality, evaluated on the live op bus during DECODE.
  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
      default:                              op_legal = 1'b0;
    endcase
  end

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Opcode latch: captured in DECODE so later op changes cannot redirect MEMADR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    op_q <= '0;
    else if (state_q == S_DECODE) op_q <= op;
  end

  // Sticky illegal flag, set on the DECODE cycle that diverts to HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    illegal <= 1'b0;
    else if (state_q == S_DECODE && !op_legal)  illegal <= 1'b1;
  end

  // Retired-instruction counter, 9-bit modulo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ictr <= '0;
    else if (retire) ictr <= ictr + 9'd1;
  end

  // Next-state decode and retire detection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ack) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ack) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase

    retire = 1'b0;
    if (state_d == S_FETCH &&
        (state_q == S_MEMWB || state_q == S_MEMWR || state_q == S_RWB ||
         state_q == S_BRANCH || state_q == S_JUMP))
      retire = 1'b1;
  end

  // Output decode; every strobe is forced low while rst is high so that
  // FETCH does not request memory during reset.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    reg_write = 1'b0;
    alu_op    = ALU_ADD;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ack;
          pc_write = mem_ack;
          pc_src   = PC_PLUS4;
        end
        S_MEMADR: alu_op = ALU_ADD;
        S_MEMRD:  mem_req = 1'b1;
        S_MEMWB:  reg_write = 1'b1;
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        S_EXEC:   alu_op = ALU_FUNCT;
        S_RWB:    reg_write = 1'b1;
        S_BRANCH: begin
          alu_op   = ALU_SUB;
          pc_src   = PC_BRANCH;
          pc_write = zero;
        end
        S_JUMP: begin
          pc_src   = PC_JUMP;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed self-checking bench for ctrl_fsm.
module tb_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, ir_write, pc_write, reg_write, illegal;
  logic [1:0] pc_src, alu_op;
  logic [3:0] state;
  logic [8:0] ictr;

  int n_checks = 0;
  int n_pass   = 0;

  ctrl_fsm dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .alu_op(alu_op), .state(state), .ictr(ictr), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs are driven 2 time units after a rising edge and outputs
  // sampled 1 unit later, well away from the next edge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic ack);
    mem_ack = ack;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ack = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_mem_req", mem_req, 0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    // ---------------- reset values, strobes suppressed with ack high
    rst = 1'b1;
    mem_ack = 1'b1;
    #3;
    check("reset_state", state, 0);
    check("reset_ictr", ictr, 0);
    check("reset_illegal", illegal, 0);
    check("reset_mem_req", mem_req, 0);
    check("reset_ir_write", ir_write, 0);
    check("reset_pc_write", pc_write, 0);

    // ---------------- lw path: 0,0,0,1,2,3,3,3,4,0
    do_reset();
    op = 6'b100011;
    drive(0); check("lw_s1", state, 0); check("lw_req1", mem_req, 1); check("lw_irw1", ir_write, 0);
    next_cycle();
    drive(0); check("lw_s2", state, 0); check("lw_req2", mem_req, 1);
    next_cycle();
    drive(1); check("lw_s3", state, 0); check("lw_irw3", ir_write, 1);
    check("lw_pcw3", pc_write, 1); check("lw_pcsrc3", pc_src, 0);
    next_cycle();
    drive(0); check("lw_s4", state, 1); check("lw_req4", mem_req, 0); check("lw_rw4", reg_write, 0);
    next_cycle();
    drive(0); check("lw_s5", state, 2); check("lw_alu5", alu_op, 0); check("lw_req5", mem_req, 0);
    next_cycle();
    drive(0); check("lw_s6", state, 3); check("lw_req6", mem_req, 1); check("lw_rw6", reg_write, 0);
    next_cycle();
    drive(0); check("lw_s7", state, 3); check("lw_req7", mem_req, 1);
    next_cycle();
    drive(1); check("lw_s8", state, 3); check("lw_req8", mem_req, 1); check("lw_we8", mem_we, 0);
    next_cycle();
    drive(0); check("lw_s9", state, 4); check("lw_rw9", reg_write, 1); check("lw_req9", mem_req, 0);
    check("lw_ictr9", ictr, 0);
    next_cycle();
    drive(0); check("lw_s10", state, 0); check("lw_rw10", reg_write, 0); check("lw_ictr10", ictr, 1);

    // ---------------- beq taken then not taken
    do_reset();
    op = 6'b000100;
    zero = 1'b1;
    drive(1); check("beq1_fetch", state, 0);
    next_cycle();
    drive(0); check("beq1_dec", state, 1);
    next_cycle();
    drive(0); check("beq1_s", state, 8); check("beq1_pcw", pc_write, 1);
    check("beq1_pcsrc", pc_src, 1); check("beq1_alu", alu_op, 1);
    next_cycle();
    zero = 1'b0;
    drive(1); check("beq2_fetch", state, 0); check("beq_ictr1", ictr, 1);
    next_cycle();
    drive(0); check("beq2_dec", state, 1);
    next_cycle();
    drive(0); check("beq2_s", state, 8); check("beq2_pcw", pc_write, 0); check("beq2_pcsrc", pc_src, 1);
    next_cycle();
    drive(0); check("beq2_back", state, 0); check("beq_ictr2", ictr, 2);

    // ---------------- illegal opcode -> HALT, ack ignored while halted
    do_reset();
    op = 6'b111111;
    drive(1);
    next_cycle();
    drive(1); check("ill_dec", state, 1); check("ill_flag_pre", illegal, 0);
    next_cycle();
    op = 6'b000010;
    for (int i = 0; i < 20; i++) begin
      drive(1);
      check("ill_state", state, 10);
      check("ill_flag", illegal, 1);
      check("ill_mem_req", mem_req, 0);
      check("ill_pc_write", pc_write, 0);
      check("ill_ictr", ictr, 0);
      next_cycle();
    end

    // ---------------- 512 back-to-back jumps, ictr wraps
    do_reset();
    op = 6'b000010;
    for (int i = 0; i < 512; i++) begin
      drive(1); check("j_fetch", state, 0); check("j_ictr", ictr, i);
      next_cycle();
      drive(1); check("j_dec", state, 1);
      next_cycle();
      drive(1); check("j_state", state, 9); check("j_pcsrc", pc_src, 2); check("j_pcw", pc_write, 1);
      next_cycle();
    end
    drive(1); check("j_wrap_state", state, 0); check("j_wrap_ictr", ictr, 0);

    // ---------------- async reset in MEMWR mid-handshake
    do_reset();
    op = 6'b101011;
    drive(1);
    next_cycle();
    drive(0); check("ar_dec", state, 1);
    next_cycle();
    drive(0); check("ar_adr", state, 2);
    next_cycle();
    drive(0); check("ar_memwr", state, 5); check("ar_we", mem_we, 1); check("ar_req", mem_req, 1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_async_state", state, 0);
    check("ar_async_req", mem_req, 0);
    check("ar_async_we", mem_we, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("ar_rel_state", state, 0); check("ar_rel_req", mem_req, 1); check("ar_rel_ictr", ictr, 0);
    next_cycle();
    drive(1); check("ar_fetch", state, 0); check("ar_irw", ir_write, 1);
    next_cycle();
    drive(0); check("ar_decode", state, 1);

    // ---------------- sw with op changed during MEMADR
    do_reset();
    op = 6'b101011;
    drive(1);
    next_cycle();
    drive(0); check("sw_dec", state, 1);
    next_cycle();
    op = 6'b000100;
    drive(0); check("sw_adr", state, 2); check("sw_alu", alu_op, 0);
    next_cycle();
    drive(0); check("sw_memwr", state, 5); check("sw_we", mem_we, 1); check("sw_req", mem_req, 1);
    next_cycle();
    drive(1); check("sw_hold", state, 5); check("sw_we2", mem_we, 1);
    next_cycle();
    drive(0); check("sw_done", state, 0); check("sw_ictr", ictr, 1); check("sw_we3", mem_we, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
